operand_fetch_stage: RTL

//  ID->EX boundary stage of the RV32 pipeline, directly upstream of Vr_register_file.

---
 rtl/operand_fetch_stage.sv | 119 +++++++++++
 1 files changed

// File: rtl/operand_fetch_stage.sv
// ID->EX boundary: register file read, EX/MEM/WB operand forwarding, load-use
// hazard detection and the ID/EX pipeline register with a valid/ready handshake.
module operand_fetch_stage #(
    parameter int CTRL_W = 16,
    parameter int XLEN   = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [4:0]        id_rd,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    output logic [4:0]        RR1,
    output logic [4:0]        RR2,
    input  logic [XLEN-1:0]   RD1,
    input  logic [XLEN-1:0]   RD2,
    input  logic              ex_fwd_we,
    input  logic [4:0]        ex_fwd_rd,
    input  logic [XLEN-1:0]   ex_fwd_data,
    input  logic              ex_is_load,
    input  logic              mem_fwd_we,
    input  logic [4:0]        mem_fwd_rd,
    input  logic [XLEN-1:0]   mem_fwd_data,
    input  logic              wb_we,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [XLEN-1:0]   ex_op1,
    output logic [XLEN-1:0]   ex_op2,
    output logic [4:0]        ex_rd,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [31:0]       stall_cnt
);

    logic [XLEN-1:0] op1_fwd;
    logic [XLEN-1:0] op2_fwd;
    logic            load_use;
    logic            capture;
    logic            stall;

    assign RR1 = id_rs1;
    assign RR2 = id_rs2;

    // The WB stage is bypassed because the register file only updates at the edge.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [4:0]      rs,
        input logic [XLEN-1:0] rf_data,
        input logic            e_we,
        input logic [4:0]      e_rd,
        input logic [XLEN-1:0] e_data,
        input logic            m_we,
        input logic [4:0]      m_rd,
        input logic [XLEN-1:0] m_data,
        input logic            w_we,
        input logic [4:0]      w_rd,
        input logic [XLEN-1:0] w_data
    );
        if (rs == 5'd0)                return '0;
        else if (e_we && e_rd == rs)   return e_data;
        else if (m_we && m_rd == rs)   return m_data;
        else if (w_we && w_rd == rs)   return w_data;
        else                           return rf_data;
    endfunction

    always_comb begin
        op1_fwd = fwd_sel(id_rs1, RD1, ex_fwd_we, ex_fwd_rd, ex_fwd_data,
                          mem_fwd_we, mem_fwd_rd, mem_fwd_data, wb_we, wb_rd, wb_data);
        op2_fwd = fwd_sel(id_rs2, RD2, ex_fwd_we, ex_fwd_rd, ex_fwd_data,
                          mem_fwd_we, mem_fwd_rd, mem_fwd_data, wb_we, wb_rd, wb_data);
    end

    assign load_use = ex_is_load && ex_fwd_we && (ex_fwd_rd != 5'd0) &&
                      ((id_use_rs1 && id_rs1 == ex_fwd_rd) ||
                       (id_use_rs2 && id_rs2 == ex_fwd_rd));
    assign id_ready = flush || (!load_use && (!ex_valid || ex_ready));
    assign capture  = id_valid && id_ready && !flush;
    assign stall    = load_use && id_valid && !flush;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ex_valid  <= 1'b0;
            ex_op1    <= '0;
            ex_op2    <= '0;
            ex_rd     <= '0;
            ex_pc     <= '0;
            ex_imm    <= '0;
            ex_ctrl   <= '0;
            stall_cnt <= '0;
        end else begin
            if (flush) begin
                ex_valid <= 1'b0;
            end else if (capture) begin
                ex_valid <= 1'b1;
                ex_op1   <= op1_fwd;
                ex_op2   <= op2_fwd;
                ex_rd    <= id_rd;
                ex_pc    <= id_pc;
                ex_imm   <= id_imm;
                ex_ctrl  <= id_ctrl;
            end else if (ex_ready) begin
                // covers both the drain case and the bubble inserted on a stall
                ex_valid <= 1'b0;
            end
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule
